// File: rtl/led_pwm_ctrl_if.sv
// Configuration write port of led_pwm_ctrl: one-deep write with a ready handshake.
// The master drives a channel update and the slave returns cfg_ready.
interface led_pwm_ctrl_if #(
  parameter int unsigned N_LEDS     = 8,
  parameter int unsigned PWM_BITS   = 8,
  parameter int unsigned BLINK_BITS = 8
);
  localparam int unsigned CH_W = (N_LEDS > 1) ? $clog2(N_LEDS) : 1;

  logic                  cfg_we;
  logic [CH_W-1:0]       cfg_ch;
  logic [1:0]            cfg_mode;
  logic [PWM_BITS-1:0]   cfg_duty;
  logic [BLINK_BITS-1:0] cfg_half;
  logic                  cfg_ready;

  modport master (
    output cfg_we, cfg_ch, cfg_mode, cfg_duty, cfg_half,
    input  cfg_ready
  );

  modport slave (
    input  cfg_we, cfg_ch, cfg_mode, cfg_duty, cfg_half,
    output cfg_ready
  );
endinterface

// File: rtl/led_pwm_ctrl.sv
// Multi-channel LED driver: OFF / ON / PWM / blinking-PWM per channel.
// Config writes wait in a one-deep buffer and commit only at PWM frame boundaries.
module led_pwm_ctrl #(
  parameter int unsigned N_LEDS     = 8,
  parameter int unsigned PWM_BITS   = 8,
  parameter int unsigned PRESCALE   = 256,
  parameter int unsigned BLINK_BITS = 8,
  parameter bit          LED_INV    = 1'b0
) (
  input  logic              clk,
  input  logic              rstn,
  led_pwm_ctrl_if.slave     bus,
  output logic              frame,
  output logic [N_LEDS-1:0] led
);
  localparam int unsigned CH_W  = (N_LEDS > 1) ? $clog2(N_LEDS) : 1;
  localparam int unsigned PSC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(PRESCALE - 1);

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_PWM   = 2'd2,
    MODE_BLINK = 2'd3
  } mode_e;

  typedef struct packed {
    logic [CH_W-1:0]       ch;
    mode_e                 mode;
    logic [PWM_BITS-1:0]   duty;
    logic [BLINK_BITS-1:0] half;
  } cfg_t;

  typedef enum logic {
    PEND_EMPTY = 1'b0,
    PEND_FULL  = 1'b1
  } pend_state_e;

  logic [PSC_W-1:0]      psc, psc_n;
  logic [PWM_BITS-1:0]   pwm, pwm_n;
  logic                  step_c;

  pend_state_e           state, state_n;
  logic                  accept_c, commit_c, ch_ok_c;
  logic                  ready_q;
  cfg_t                  pend;

  mode_e                 mode_q [N_LEDS];
  logic [PWM_BITS-1:0]   duty_q [N_LEDS];
  logic [BLINK_BITS-1:0] half_q [N_LEDS];
  logic [BLINK_BITS-1:0] bc_q   [N_LEDS];
  logic [N_LEDS-1:0]     ph_q;
  logic [N_LEDS-1:0]     blink_last_c;
  logic [N_LEDS-1:0]     level_c;

  // Prescaler and PWM step counter
  always_comb begin
    step_c = (psc == PSC_LAST);
    psc_n  = step_c ? '0 : psc + PSC_W'(1);
    pwm_n  = pwm + PWM_BITS'(step_c);
  end

  // frame is high exactly while psc=PRESCALE-1 and pwm=all-ones
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      psc   <= '0;
      pwm   <= '0;
      frame <= 1'b0;
    end else begin
      psc   <= psc_n;
      pwm   <= pwm_n;
      frame <= (psc_n == PSC_LAST) && (pwm_n == '1);
    end
  end

  assign ch_ok_c = (32'(bus.cfg_ch) < N_LEDS);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= PEND_EMPTY;
    else       state <= state_n;
  end

  // A capture only moves to FULL, so a write landing on a frame pulse waits a frame
  always_comb begin
    state_n  = state;
    accept_c = 1'b0;
    commit_c = 1'b0;
    case (state)
      PEND_EMPTY: begin
        if (bus.cfg_we && ch_ok_c) begin
          accept_c = 1'b1;
          state_n  = PEND_FULL;
        end
      end
      PEND_FULL: begin
        if (frame) begin
          commit_c = 1'b1;
          state_n  = PEND_EMPTY;
        end
      end
      default: state_n = PEND_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ready_q <= 1'b1;
      pend    <= '0;
    end else begin
      ready_q <= (state_n == PEND_EMPTY);
      if (accept_c) begin
        pend.ch   <= bus.cfg_ch;
        pend.mode <= mode_e'(bus.cfg_mode);
        pend.duty <= bus.cfg_duty;
        pend.half <= bus.cfg_half;
      end
    end
  end

  assign bus.cfg_ready = ready_q;

  // Per-channel active registers; a commit overrides that frame's blink update
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < int'(N_LEDS); i++) begin
        mode_q[i] <= MODE_OFF;
        duty_q[i] <= '0;
        half_q[i] <= '0;
        bc_q[i]   <= '0;
        ph_q[i]   <= 1'b1;
      end
    end else begin
      for (int i = 0; i < int'(N_LEDS); i++) begin
        if (commit_c && (pend.ch == CH_W'(i))) begin
          mode_q[i] <= pend.mode;
          duty_q[i] <= pend.duty;
          half_q[i] <= pend.half;
          bc_q[i]   <= '0;
          ph_q[i]   <= 1'b1;
        end else if (frame) begin
          if (mode_q[i] == MODE_BLINK) begin
            if (blink_last_c[i]) begin
              bc_q[i] <= '0;
              ph_q[i] <= ~ph_q[i];
            end else begin
              bc_q[i] <= bc_q[i] + BLINK_BITS'(1);
            end
          end else begin
            bc_q[i] <= '0;
            ph_q[i] <= 1'b1;
          end
        end
      end
    end
  end

  // Blink terminal count is max(half,1)-1; level is the un-inverted LED state
  always_comb begin
    blink_last_c = '0;
    level_c      = '0;
    for (int i = 0; i < int'(N_LEDS); i++) begin
      blink_last_c[i] = (half_q[i] == '0) ? (bc_q[i] == '0)
                                          : (bc_q[i] == half_q[i] - BLINK_BITS'(1));
      case (mode_q[i])
        MODE_OFF:   level_c[i] = 1'b0;
        MODE_ON:    level_c[i] = 1'b1;
        MODE_PWM:   level_c[i] = (pwm < duty_q[i]);
        MODE_BLINK: level_c[i] = ph_q[i] && (pwm < duty_q[i]);
        default:    level_c[i] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) led <= {N_LEDS{LED_INV}};
    else       led <= level_c ^ {N_LEDS{LED_INV}};
  end
endmodule

// File: tb/tb_led_pwm_ctrl.sv
// Directed bench for led_pwm_ctrl: 4-channel instance (LED_INV=0) and 3-channel
// instance (LED_INV=1), PWM_BITS=4, PRESCALE=2, BLINK_BITS=4 -> 32 clk per frame.
module tb_led_pwm_ctrl;
  localparam logic [31:0] ALL  = 32'hFFFF_FFFF;
  localparam logic [31:0] D15  = 32'h3FFF_FFFF;
  localparam logic [31:0] D5   = 32'h0000_03FF;
  localparam logic [31:0] D8   = 32'h0000_FFFF;
  localparam logic [31:0] NONE = 32'h0000_0000;

  logic       clk;
  logic       rstn;
  logic       frame_a, frame_b;
  logic [3:0] led_a;
  logic [2:0] led_b;

  led_pwm_ctrl_if #(.N_LEDS(4), .PWM_BITS(4), .BLINK_BITS(4)) bus_a ();
  led_pwm_ctrl_if #(.N_LEDS(3), .PWM_BITS(4), .BLINK_BITS(4)) bus_b ();

  led_pwm_ctrl #(.N_LEDS(4), .PWM_BITS(4), .PRESCALE(2), .BLINK_BITS(4), .LED_INV(1'b0)) dut_a (
    .clk(clk), .rstn(rstn), .bus(bus_a), .frame(frame_a), .led(led_a));

  led_pwm_ctrl #(.N_LEDS(3), .PWM_BITS(4), .PRESCALE(2), .BLINK_BITS(4), .LED_INV(1'b1)) dut_b (
    .clk(clk), .rstn(rstn), .bus(bus_b), .frame(frame_b), .led(led_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int              ch;
    int              mode;
    int              duty;
    int              half;
    int              nfr;
    logic [5:0][31:0] exp;   // expected led[ch] pattern per captured frame, bit j = clk j
  } vec_t;

  vec_t       vecs [9];
  logic [3:0] samp [192];
  int         n_vec;
  int         n_bad;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic set_vec(input int i, input int ch, input int mode, input int duty,
                         input int half, input int nfr, input logic [5:0][31:0] e);
    vecs[i].ch = ch; vecs[i].mode = mode; vecs[i].duty = duty;
    vecs[i].half = half; vecs[i].nfr = nfr; vecs[i].exp = e;
  endtask

  // Drive a one-cycle write starting at the current negedge
  task automatic drive_a(input int ch, input int mode, input int duty, input int half);
    bus_a.cfg_we = 1'b1; bus_a.cfg_ch = 2'(ch); bus_a.cfg_mode = 2'(mode);
    bus_a.cfg_duty = 4'(duty); bus_a.cfg_half = 4'(half);
    @(negedge clk);
    bus_a.cfg_we = 1'b0;
  endtask

  task automatic drive_b(input int ch, input int mode, input int duty, input int half);
    bus_b.cfg_we = 1'b1; bus_b.cfg_ch = 2'(ch); bus_b.cfg_mode = 2'(mode);
    bus_b.cfg_duty = 4'(duty); bus_b.cfg_half = 4'(half);
    @(negedge clk);
    bus_b.cfg_we = 1'b0;
  endtask

  task automatic wait_ready_a(input string name);
    int n = 0;
    while (!bus_a.cfg_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(bus_a.cfg_ready), 32'd1);
  endtask

  task automatic wait_frame_a();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_a && n < 100);
    check("frame_seen", 32'(frame_a), 32'd1);
  endtask

  // Sample j reflects psc/pwm state j+1 clk after a frame pulse: pwm = (j%32)/2
  task automatic capture_a(input int nfr);
    wait_frame_a();
    @(negedge clk);
    for (int j = 0; j < nfr * 32; j++) begin
      @(negedge clk);
      samp[j] = led_a;
    end
  endtask

  function automatic logic [31:0] pat(input int ch, input int fr);
    logic [31:0] p;
    p = '0;
    for (int j = 0; j < 32; j++) p[j] = samp[fr * 32 + j][ch];
    return p;
  endfunction

  initial begin
    int n;
    logic [3:0] led_or;
    logic       rdy_and;
    n_vec = 0;
    n_bad = 0;

    set_vec(0, 1, 2,  5, 0, 1, {{5{NONE}}, D5});
    set_vec(1, 1, 2,  0, 0, 1, {{5{NONE}}, NONE});
    set_vec(2, 1, 2, 15, 0, 1, {{5{NONE}}, D15});
    set_vec(3, 0, 1,  0, 0, 1, {{5{NONE}}, ALL});
    set_vec(4, 0, 0, 15, 0, 1, {{5{NONE}}, NONE});
    set_vec(5, 2, 3, 15, 3, 6, {D15, NONE, NONE, NONE, D15, D15});
    set_vec(6, 2, 3, 15, 0, 4, {NONE, NONE, D15, NONE, D15, NONE});
    set_vec(7, 2, 3,  5, 1, 4, {NONE, NONE, D5, NONE, D5, NONE});
    set_vec(8, 1, 2,  8, 0, 1, {{5{NONE}}, D8});

    bus_a.cfg_we = 1'b0; bus_a.cfg_ch = '0; bus_a.cfg_mode = '0; bus_a.cfg_duty = '0; bus_a.cfg_half = '0;
    bus_b.cfg_we = 1'b0; bus_b.cfg_ch = '0; bus_b.cfg_mode = '0; bus_b.cfg_duty = '0; bus_b.cfg_half = '0;

    // Reset state on both polarities
    rstn = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_led_a",   32'(led_a), 32'h0);
    check("rst_ready_a", 32'(bus_a.cfg_ready), 32'd1);
    check("rst_frame_a", 32'(frame_a), 32'd0);
    check("rst_led_b",   32'(led_b), 32'h7);
    check("rst_ready_b", 32'(bus_b.cfg_ready), 32'd1);
    rstn = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_a && n < 100);
    check("first_frame_clk", 32'(n), 32'd31);

    // Out-of-range channel on the 3-channel instance is ignored
    drive_b(3, 1, 0, 0);
    check("oor_ready", 32'(bus_b.cfg_ready), 32'd1);
    repeat (40) @(negedge clk);
    check("oor_ready_hold", 32'(bus_b.cfg_ready), 32'd1);
    check("oor_led", 32'(led_b), 32'h7);
    drive_b(0, 1, 0, 0);
    check("inv_busy", 32'(bus_b.cfg_ready), 32'd0);
    n = 0;
    while (!bus_b.cfg_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("inv_ready", 32'(bus_b.cfg_ready), 32'd1);
    repeat (2) @(negedge clk);
    check("inv_led_on", 32'(led_b), 32'h6);

    // Table-driven configuration vectors
    for (int v = 0; v < 9; v++) begin
      drive_a(vecs[v].ch, vecs[v].mode, vecs[v].duty, vecs[v].half);
      check($sformatf("v%0d_busy", v), 32'(bus_a.cfg_ready), 32'd0);
      wait_ready_a($sformatf("v%0d_commit", v));
      capture_a(vecs[v].nfr);
      for (int f = 0; f < vecs[v].nfr; f++)
        check($sformatf("v%0d_ch%0d_fr%0d", v, vecs[v].ch, f), pat(vecs[v].ch, f), vecs[v].exp[f]);
    end

    // Handshake: second write while busy is dropped
    drive_a(0, 1, 0, 0);
    check("hs_busy", 32'(bus_a.cfg_ready), 32'd0);
    drive_a(3, 1, 15, 0);
    wait_ready_a("hs_commit");
    capture_a(1);
    check("hs_ch0_on",   pat(0, 0), ALL);
    check("hs_ch3_kept", pat(3, 0), NONE);
    drive_a(3, 1, 0, 0);
    check("hs_ch3_busy", 32'(bus_a.cfg_ready), 32'd0);
    wait_ready_a("hs_ch3_commit");
    capture_a(1);
    check("hs_ch3_on", pat(3, 0), ALL);

    // Write coincident with a frame pulse commits one frame later
    wait_frame_a();
    drive_a(1, 1, 0, 0);
    check("bnd_busy", 32'(bus_a.cfg_ready), 32'd0);
    n = 0;
    while (!bus_a.cfg_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("bnd_latency", 32'(n), 32'd32);
    capture_a(1);
    check("bnd_ch1_on", pat(1, 0), ALL);

    // Reset pulse with a pending write and a blinking channel
    drive_a(1, 1, 0, 0);
    check("mid_busy", 32'(bus_a.cfg_ready), 32'd0);
    rstn = 1'b0;
    #1;
    check("mid_rst_led",   32'(led_a), 32'h0);
    check("mid_rst_ready", 32'(bus_a.cfg_ready), 32'd1);
    check("mid_rst_frame", 32'(frame_a), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    led_or  = '0;
    rdy_and = 1'b1;
    repeat (96) begin
      @(negedge clk);
      led_or  = led_or | led_a;
      rdy_and = rdy_and & bus_a.cfg_ready;
    end
    check("mid_led_dark",  32'(led_or), 32'h0);
    check("mid_ready_high", 32'(rdy_and), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
